// File: rtl/carrier_detect_ctrl_pkg.sv
// Shared definitions for the carrier detector: FSM state encoding and
// accumulator width derivation.
package carrier_detect_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CAND   = 2'd1,
    LOCKED = 2'd2
  } state_e;

  // Holds 2^win_log2 magnitudes of up to 2^width each without overflow.
  function automatic int unsigned acc_w(input int unsigned width, input int unsigned win_log2);
    return width + 1 + win_log2;
  endfunction

endpackage

// File: rtl/win_accum.sv
// Magnitude register plus windowed |I|+|Q| accumulator. Also exposes the
// window-end strobe and full sum one cycle early so the FSM can update with energy.
module win_accum
  import carrier_detect_ctrl_pkg::*;
#(
  parameter  int unsigned WIDTH    = 16,
  parameter  int unsigned WIN_LOG2 = 6,
  localparam int unsigned ACC_W    = acc_w(WIDTH, WIN_LOG2)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             vld,
  input  logic [WIDTH-1:0] in_i,
  input  logic [WIDTH-1:0] in_q,
  output logic [ACC_W-1:0] energy,
  output logic             energy_vld,
  output logic             win_end_c,
  output logic [ACC_W-1:0] sum_c
);

  localparam int unsigned MAG_W = WIDTH + 1;

  logic [MAG_W-1:0]    mag;
  logic                mag_vld;
  logic [MAG_W-1:0]    mag_d;
  logic [ACC_W-1:0]    acc;
  logic [WIN_LOG2-1:0] cnt;

  // Sign-extend first so the most negative input maps to +2^(WIDTH-1).
  function automatic logic [MAG_W-1:0] abs_ext(input logic [WIDTH-1:0] x);
    logic [MAG_W-1:0] ext;
    ext = {x[WIDTH-1], x};
    return x[WIDTH-1] ? (~ext + MAG_W'(1)) : ext;
  endfunction

  assign mag_d     = abs_ext(in_i) + abs_ext(in_q);
  assign sum_c     = acc + ACC_W'(mag);
  assign win_end_c = mag_vld && (cnt == '1);

  always_ff @(posedge clk) begin
    if (rst || !en) begin
      mag        <= '0;
      mag_vld    <= 1'b0;
      acc        <= '0;
      cnt        <= '0;
      energy     <= '0;
      energy_vld <= 1'b0;
    end else begin
      mag_vld    <= vld;
      energy_vld <= win_end_c;
      if (vld) mag <= mag_d;
      if (mag_vld) cnt <= cnt + WIN_LOG2'(1);
      // Restart at zero so the next valid magnitude opens the new window.
      if (win_end_c) begin
        energy <= sum_c;
        acc    <= '0;
      end else if (mag_vld) begin
        acc <= sum_c;
      end
    end
  end

endmodule

// File: rtl/carrier_detect_ctrl.sv
// Energy-based carrier detector: windowed |I|+|Q| energy feeding a
// lock/unlock FSM with on/off hysteresis and consecutive-window qualification.
module carrier_detect_ctrl
  import carrier_detect_ctrl_pkg::*;
#(
  parameter  int unsigned WIDTH    = 16,
  parameter  int unsigned WIN_LOG2 = 6,
  parameter  int unsigned ON_CNT   = 2,
  parameter  int unsigned OFF_CNT  = 4,
  localparam int unsigned ACC_W    = acc_w(WIDTH, WIN_LOG2)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             vld,
  input  logic [WIDTH-1:0] in_i,
  input  logic [WIDTH-1:0] in_q,
  input  logic [ACC_W-1:0] thr_on,
  input  logic [ACC_W-1:0] thr_off,
  output logic [ACC_W-1:0] energy,
  output logic             energy_vld,
  output logic             detect,
  output logic [1:0]       state
);

  localparam int unsigned ON_W  = $clog2(ON_CNT + 1);
  localparam int unsigned OFF_W = $clog2(OFF_CNT + 1);

  logic             win_end_c;
  logic [ACC_W-1:0] sum_c;

  state_e           state_q, state_d;
  logic [ON_W-1:0]  on_q, on_d;
  logic [OFF_W-1:0] off_q, off_d;
  logic             detect_q, detect_d;

  win_accum #(
    .WIDTH    (WIDTH),
    .WIN_LOG2 (WIN_LOG2)
  ) u_win_accum (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .vld        (vld),
    .in_i       (in_i),
    .in_q       (in_q),
    .energy     (energy),
    .energy_vld (energy_vld),
    .win_end_c  (win_end_c),
    .sum_c      (sum_c)
  );

  always_ff @(posedge clk) begin
    if (rst || !en) begin
      state_q  <= IDLE;
      on_q     <= '0;
      off_q    <= '0;
      detect_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      on_q     <= on_d;
      off_q    <= off_d;
      detect_q <= detect_d;
    end
  end

  // Evaluated on the window-end cycle so state lands with energy_vld.
  always_comb begin
    state_d = state_q;
    on_d    = on_q;
    off_d   = off_q;
    unique case (state_q)
      IDLE: begin
        if (win_end_c && (sum_c >= thr_on)) begin
          if (ON_CNT <= 1) begin
            state_d = LOCKED;
            on_d    = '0;
            off_d   = '0;
          end else begin
            state_d = CAND;
            on_d    = ON_W'(1);
          end
        end
      end
      CAND: begin
        if (win_end_c) begin
          if (sum_c >= thr_on) begin
            if ((on_q + ON_W'(1)) == ON_W'(ON_CNT)) begin
              state_d = LOCKED;
              on_d    = '0;
              off_d   = '0;
            end else begin
              on_d = on_q + ON_W'(1);
            end
          end else begin
            state_d = IDLE;
            on_d    = '0;
          end
        end
      end
      LOCKED: begin
        if (win_end_c) begin
          if (sum_c < thr_off) begin
            if ((off_q + OFF_W'(1)) == OFF_W'(OFF_CNT)) begin
              state_d = IDLE;
              off_d   = '0;
            end else begin
              off_d = off_q + OFF_W'(1);
            end
          end else begin
            off_d = '0;
          end
        end
      end
      default: begin
        state_d = IDLE;
        on_d    = '0;
        off_d   = '0;
      end
    endcase
    detect_d = (state_d == LOCKED);
  end

  assign state  = state_q;
  assign detect = detect_q;

endmodule
